// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcodes, FSM state encoding and ula operation codes for controle_proc
package ctrl_pkg;
    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_CMP = 3'b101;
    localparam logic [1:0] ULA_ADD = 2'b00;
    localparam logic [1:0] ULA_SUB = 2'b01;
    localparam logic [1:0] ULA_SLT = 2'b10;
    localparam logic [1:0] ULA_CMP = 2'b11;
    typedef enum logic [1:0] {T0 = 2'b00, T1 = 2'b01, T2 = 2'b10, T3 = 2'b11} state_t;
endpackage

// File: rtl/regn.sv
// regn: W-bit register with write enable and synchronous active-high reset
module regn #(parameter int W = 16) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk)
        if (rst) q <= '0;
        else if (en) q <= d;
endmodule

// File: rtl/controle_proc.sv
// controle_proc: multi-cycle control/datapath stage feeding the 16-bit ula; Illegal port only with CTRL_ILLEGAL_FLAG_EN
module controle_proc
    import ctrl_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    input  logic [DATA_W-1:0] UlaQ,
    output logic [DATA_W-1:0] RegA,
    output logic [DATA_W-1:0] BusWires,
    output logic [1:0]        Operacao,
    output logic              Done
`ifdef CTRL_ILLEGAL_FLAG_EN
    ,output logic             Illegal
`endif
);
    state_t state, nxt;
    logic [8:0] ir;
    logic [2:0] op, rx, ry;
    logic [DATA_W-1:0] r [8];
    logic [DATA_W-1:0] g, bus;
    logic [7:0] sel_r, r_en;
    logic sel_din, sel_g, r_wr, a_en, g_en;

    assign {op, rx, ry} = ir;
    assign r_en = {7'b0, r_wr} << rx;
    assign BusWires = bus;
`ifdef CTRL_ILLEGAL_FLAG_EN
    // only 11x opcodes finish with Done while still in T1 without a write
    assign Illegal = Done && op[2:1] == 2'b11;
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= T0;
            ir <= '0;
        end else begin
            state <= nxt;
            if (state == T0 && Run) ir <= DIN[8:0];
        end
    end

    always_comb begin
        nxt = state;
        sel_din = 1'b0;
        sel_g = 1'b0;
        sel_r = '0;
        r_wr = 1'b0;
        a_en = 1'b0;
        g_en = 1'b0;
        Done = 1'b0;
        Operacao = ULA_ADD;
        if (!Reset)
            case (state)
                T0: nxt = Run ? T1 : T0;
                T1: begin
                    nxt = T0;
                    case (op)
                        OP_MV: begin
                            sel_r[ry] = 1'b1;
                            r_wr = 1'b1;
                            Done = 1'b1;
                        end
                        OP_MVI: begin
                            sel_din = 1'b1;
                            r_wr = 1'b1;
                            Done = 1'b1;
                        end
                        OP_ADD, OP_SUB, OP_SLT, OP_CMP: begin
                            sel_r[rx] = 1'b1;
                            a_en = 1'b1;
                            nxt = T2;
                        end
                        default: Done = 1'b1;
                    endcase
                end
                T2: begin
                    sel_r[ry] = 1'b1;
                    g_en = 1'b1;
                    Operacao = op == OP_SUB ? ULA_SUB : op == OP_SLT ? ULA_SLT : op == OP_CMP ? ULA_CMP : ULA_ADD;
                    nxt = T3;
                end
                T3: begin
                    sel_g = 1'b1;
                    r_wr = 1'b1;
                    Done = 1'b1;
                    nxt = T0;
                end
                default: nxt = T0;
            endcase
    end

    // one-hot AND-OR bus: all-zero selects give a zero bus
    always_comb begin
        bus = ({DATA_W{sel_din}} & DIN) | ({DATA_W{sel_g}} & g);
        for (int k = 0; k < 8; k++) bus |= {DATA_W{sel_r[k]}} & r[k];
    end

    for (genvar i = 0; i < 8; i++) begin : g_r
        regn #(.W(DATA_W)) u_r (.clk(Clock), .rst(Reset), .en(r_en[i]), .d(bus), .q(r[i]));
    end
    regn #(.W(DATA_W)) u_a (.clk(Clock), .rst(Reset), .en(a_en), .d(bus), .q(RegA));
    regn #(.W(DATA_W)) u_g (.clk(Clock), .rst(Reset), .en(g_en), .d(UlaQ), .q(g));
endmodule
